// File: rtl/axonerve_kvs_pkg.sv
// Shared types, field layout and opcode classification for the KVS command unpacker.
package axonerve_kvs_pkg;

   localparam int unsigned OPCODE_WIDTH = 8;
   localparam int unsigned KEY_LSB      = 0;

   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_NOP    = 8'd0,
      OP_SEARCH = 8'd1,
      OP_INSERT = 8'd2,
      OP_DELETE = 8'd3,
      OP_UPDATE = 8'd4
   } kvs_opcode_e;

   // Beat buffer occupancy; HOLD whenever any lane is still pending.
   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_HOLD  = 1'b1
   } buf_state_e;

   // Only the four engine operations are forwarded; everything else is dropped.
   function automatic logic is_legal_opcode(input logic [OPCODE_WIDTH-1:0] op);
      case (op)
         OP_SEARCH, OP_INSERT, OP_DELETE, OP_UPDATE: return 1'b1;
         default:                                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/axonerve_kvs_lane_select.sv
// Lowest-set-bit priority select over the pending lane mask.
module axonerve_kvs_lane_select #(
   parameter int unsigned LANES = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [LANES-1:0] mask_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [LANES-1:0] onehot_o,
   output logic             single_o
);

   logic found;

   // Scan from lane 0 upward so the oldest record in the beat leaves first.
   always_comb begin
      idx_o    = '0;
      onehot_o = '0;
      found    = 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (mask_i[l] && !found) begin
            idx_o       = IDX_W'(l);
            onehot_o[l] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing.
   always_comb begin
      single_o = (mask_i != '0) && ((mask_i & ~onehot_o) == '0);
   end

endmodule

// File: rtl/axonerve_kvs_cmd_unpacker.sv
// Splits wide AXI-Stream beats into KVS command records, drops NOP/illegal
// records and issues the legal ones one per cycle to the engine.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// BUF_EMPTY | pending mask is zero; ready for a new beat
// BUF_HOLD  | beat buffered, at least one legal record still to be issued
module axonerve_kvs_cmd_unpacker
   import axonerve_kvs_pkg::*;
#(
   parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
   parameter int unsigned C_RECORD_WIDTH     = 128,
   parameter int unsigned C_KEY_WIDTH        = 64,
   parameter int unsigned C_VALUE_WIDTH      = 32,
   parameter int unsigned C_COUNT_WIDTH      = 32
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic                          m_cmd_valid,
   input  logic                          m_cmd_ready,
   output logic [OPCODE_WIDTH-1:0]       m_cmd_opcode,
   output logic [C_KEY_WIDTH-1:0]        m_cmd_key,
   output logic [C_VALUE_WIDTH-1:0]      m_cmd_value,
   output logic                          m_cmd_last,
   output logic                          batch_done,
   input  logic                          ctrl_clear,
   output logic [C_COUNT_WIDTH-1:0]      cmd_count,
   output logic [C_COUNT_WIDTH-1:0]      drop_count,
   output logic                          err_sticky
);

   localparam int unsigned LANES   = C_AXIS_TDATA_WIDTH / C_RECORD_WIDTH;
   localparam int unsigned IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned VAL_LSB = KEY_LSB + C_KEY_WIDTH;
   localparam int unsigned RSV_LSB = VAL_LSB + C_VALUE_WIDTH;
   localparam int unsigned OPC_LSB = C_RECORD_WIDTH - OPCODE_WIDTH;
   localparam int unsigned RSV_W   = OPC_LSB - RSV_LSB;
   localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = 1;

   logic [OPCODE_WIDTH-1:0]  opc_q [LANES];
   logic [OPCODE_WIDTH-1:0]  opc_d [LANES];
   logic [C_KEY_WIDTH-1:0]   key_q [LANES];
   logic [C_KEY_WIDTH-1:0]   key_d [LANES];
   logic [C_VALUE_WIDTH-1:0] val_q [LANES];
   logic [C_VALUE_WIDTH-1:0] val_d [LANES];
   logic [LANES-1:0]         mask_q, mask_d;
   logic                     last_q, last_d;
   logic                     batch_done_q, batch_done_d;
   logic [C_COUNT_WIDTH-1:0] cmd_count_q, cmd_count_d;
   logic [C_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;
   logic                     err_q, err_d;

   logic [OPCODE_WIDTH-1:0]  in_opc [LANES];
   logic [C_KEY_WIDTH-1:0]   in_key [LANES];
   logic [C_VALUE_WIDTH-1:0] in_val [LANES];
   logic [LANES-1:0]         in_legal, in_illegal;
   logic [C_COUNT_WIDTH-1:0] drop_inc;
   logic                     unused_rsv_bits;

   logic [IDX_W-1:0]         sel_idx;
   logic [LANES-1:0]         sel_onehot;
   logic                     sel_single;
   buf_state_e               buf_state;
   logic                     cmd_hs, accept;

   axonerve_kvs_lane_select #(
      .LANES (LANES),
      .IDX_W (IDX_W)
   ) u_lane_select (
      .mask_i   (mask_q),
      .idx_o    (sel_idx),
      .onehot_o (sel_onehot),
      .single_o (sel_single)
   );

   // Unpack the incoming beat into fields and classify every lane.
   always_comb begin
      drop_inc        = '0;
      unused_rsv_bits = 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
         in_opc[l]     = s_axis_tdata[l*C_RECORD_WIDTH + OPC_LSB +: OPCODE_WIDTH];
         in_key[l]     = s_axis_tdata[l*C_RECORD_WIDTH + KEY_LSB +: C_KEY_WIDTH];
         in_val[l]     = s_axis_tdata[l*C_RECORD_WIDTH + VAL_LSB +: C_VALUE_WIDTH];
         in_legal[l]   = is_legal_opcode(in_opc[l]);
         in_illegal[l] = !in_legal[l] && (in_opc[l] != OP_NOP);
         if (!in_legal[l]) drop_inc = drop_inc + CNT_ONE;
         unused_rsv_bits = unused_rsv_bits ^ (^s_axis_tdata[l*C_RECORD_WIDTH + RSV_LSB +: RSV_W]);
      end
   end

   // Handshake qualification; the buffer refills in the same cycle its last record leaves.
   always_comb begin
      buf_state     = (mask_q != '0) ? BUF_HOLD : BUF_EMPTY;
      m_cmd_valid   = (buf_state == BUF_HOLD);
      m_cmd_last    = last_q && sel_single;
      cmd_hs        = m_cmd_valid && m_cmd_ready;
      s_axis_tready = !areset && ((buf_state == BUF_EMPTY) || (sel_single && cmd_hs));
      accept        = s_axis_tvalid && s_axis_tready;
   end

   // Next-state for buffer, completion pulse and statistics.
   always_comb begin
      mask_d       = mask_q;
      last_d       = last_q;
      opc_d        = opc_q;
      key_d        = key_q;
      val_d        = val_q;
      batch_done_d = cmd_hs && m_cmd_last;
      cmd_count_d  = cmd_count_q;
      drop_count_d = drop_count_q;
      err_d        = err_q;

      if (accept) begin
         mask_d = in_legal;
         last_d = s_axis_tlast;
         opc_d  = in_opc;
         key_d  = in_key;
         val_d  = in_val;
         if (in_legal == '0 && s_axis_tlast) batch_done_d = 1'b1;
      end else if (cmd_hs) begin
         mask_d = mask_q & ~sel_onehot;
      end

      if (ctrl_clear) begin
         cmd_count_d  = '0;
         drop_count_d = '0;
         err_d        = 1'b0;
      end else begin
         if (cmd_hs)                     cmd_count_d  = cmd_count_q + CNT_ONE;
         if (accept)                     drop_count_d = drop_count_q + drop_inc;
         if (accept && in_illegal != '0) err_d        = 1'b1;
      end
   end

   // State register; reset discards any buffered beat without signalling completion.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         mask_q       <= '0;
         last_q       <= 1'b0;
         batch_done_q <= 1'b0;
         cmd_count_q  <= '0;
         drop_count_q <= '0;
         err_q        <= 1'b0;
         for (int unsigned l = 0; l < LANES; l++) begin
            opc_q[l] <= '0;
            key_q[l] <= '0;
            val_q[l] <= '0;
         end
      end else begin
         mask_q       <= mask_d;
         last_q       <= last_d;
         batch_done_q <= batch_done_d;
         cmd_count_q  <= cmd_count_d;
         drop_count_q <= drop_count_d;
         err_q        <= err_d;
         opc_q        <= opc_d;
         key_q        <= key_d;
         val_q        <= val_d;
      end
   end

   // Command fields come straight from the buffer through the lane select.
   always_comb begin
      m_cmd_opcode = opc_q[sel_idx];
      m_cmd_key    = key_q[sel_idx];
      m_cmd_value  = val_q[sel_idx];
   end

   assign batch_done = batch_done_q;
   assign cmd_count  = cmd_count_q;
   assign drop_count = drop_count_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_axonerve_kvs_cmd_unpacker.sv
// Randomized bench for the KVS command unpacker with a record-level reference model.
module tb_axonerve_kvs_cmd_unpacker;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic [511:0] s_axis_tdata = '0;
   logic         s_axis_tlast = 1'b0;
   logic         m_cmd_valid;
   logic         m_cmd_ready = 1'b0;
   logic [7:0]   m_cmd_opcode;
   logic [63:0]  m_cmd_key;
   logic [31:0]  m_cmd_value;
   logic         m_cmd_last;
   logic         batch_done;
   logic         ctrl_clear = 1'b0;
   logic [31:0]  cmd_count;
   logic [31:0]  drop_count;
   logic         err_sticky;

   axonerve_kvs_cmd_unpacker dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .m_cmd_valid   (m_cmd_valid),
      .m_cmd_ready   (m_cmd_ready),
      .m_cmd_opcode  (m_cmd_opcode),
      .m_cmd_key     (m_cmd_key),
      .m_cmd_value   (m_cmd_value),
      .m_cmd_last    (m_cmd_last),
      .batch_done    (batch_done),
      .ctrl_clear    (ctrl_clear),
      .cmd_count     (cmd_count),
      .drop_count    (drop_count),
      .err_sticky    (err_sticky)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [7:0]  op;
      logic [63:0] key;
      logic [31:0] val;
      bit          last;
   } cmd_t;

   int          n_vec = 0;
   int          n_err = 0;
   logic [511:0] bq_data[$];
   bit          bq_last[$];
   cmd_t        exq[$];
   int          hs_cyc[$];
   int          acc_cyc[$];
   int          bd_cyc[$];
   int unsigned m_cmd  = 0;
   int unsigned m_drop = 0;
   bit          m_err  = 0;
   int          ready_mode = 0;  // 0 always ready, 1 random, 2 toggling

   function automatic logic [127:0] mk_rec(input logic [7:0] op);
      logic [63:0] key;
      logic [31:0] val;
      logic [23:0] rsv;
      key = {$urandom, $urandom};
      val = $urandom;
      rsv = 24'($urandom);
      return {op, rsv, val, key};
   endfunction

   function automatic logic [511:0] mk_beat(input logic [7:0] o0, input logic [7:0] o1,
                                            input logic [7:0] o2, input logic [7:0] o3);
      return {mk_rec(o3), mk_rec(o2), mk_rec(o1), mk_rec(o0)};
   endfunction

   function automatic logic [7:0] rand_op();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      return 8'($urandom_range(1, 4));
      else if (r < 8) return 8'd0;
      else            return 8'($urandom_range(5, 255));
   endfunction

   // Drives queued beats and checks every output cycle against the record-level model.
   task automatic run_stream(input int max_cycles);
      bit   exp_bd, exp_rdy, hs, acc, keep_valid, any_legal;
      int   idle, c, npush;
      logic [7:0] op;
      logic [127:0] rec;
      cmd_t e;
      hs_cyc.delete(); acc_cyc.delete(); bd_cyc.delete();
      exp_bd = 0; keep_valid = 0; idle = 0;
      ctrl_clear = 1'b0;
      for (c = 0; c < max_cycles; c++) begin
         @(posedge aclk); #1;
         s_axis_tvalid = (bq_data.size() != 0) &&
                         (keep_valid || ready_mode != 1 || $urandom_range(0, 3) != 0);
         if (s_axis_tvalid) begin
            s_axis_tdata = bq_data[0];
            s_axis_tlast = bq_last[0];
         end
         case (ready_mode)
            0:       m_cmd_ready = 1'b1;
            1:       m_cmd_ready = ($urandom_range(0, 2) != 0);
            default: m_cmd_ready = c[0];
         endcase
         @(negedge aclk);
         if (batch_done === 1'b1) bd_cyc.push_back(c);
         n_vec++;
         if (batch_done !== exp_bd) begin
            n_err++; $display("FAIL batch_done c=%0d: got %b want %b", c, batch_done, exp_bd);
         end
         n_vec++;
         if (m_cmd_valid !== (exq.size() != 0)) begin
            n_err++; $display("FAIL m_cmd_valid c=%0d: got %b want %b", c, m_cmd_valid, exq.size() != 0);
         end
         exp_rdy = (exq.size() == 0) || (exq.size() == 1 && m_cmd_ready);
         n_vec++;
         if (s_axis_tready !== exp_rdy) begin
            n_err++; $display("FAIL s_axis_tready c=%0d: got %b want %b", c, s_axis_tready, exp_rdy);
         end
         n_vec++;
         if (exq.size() != 0) begin
            if ({m_cmd_opcode, m_cmd_key, m_cmd_value, m_cmd_last} !==
                {exq[0].op, exq[0].key, exq[0].val, exq[0].last}) begin
               n_err++;
               $display("FAIL cmd_fields c=%0d: got op=%h key=%h val=%h last=%b want op=%h key=%h val=%h last=%b",
                        c, m_cmd_opcode, m_cmd_key, m_cmd_value, m_cmd_last,
                        exq[0].op, exq[0].key, exq[0].val, exq[0].last);
            end
         end else if (m_cmd_last !== 1'b0) begin
            n_err++; $display("FAIL m_cmd_last_idle c=%0d: got %b want 0", c, m_cmd_last);
         end
         hs = (exq.size() != 0) && m_cmd_ready;
         acc = s_axis_tvalid && exp_rdy;
         exp_bd = 0;
         if (hs) begin
            hs_cyc.push_back(c);
            if (exq[0].last) exp_bd = 1;
            void'(exq.pop_front());
            m_cmd++;
         end
         if (acc) begin
            acc_cyc.push_back(c);
            npush = 0; any_legal = 0;
            for (int l = 0; l < 4; l++) begin
               rec = s_axis_tdata[l*128 +: 128];
               op  = rec[127:120];
               if (op >= 8'd1 && op <= 8'd4) begin
                  e.op = op; e.key = rec[63:0]; e.val = rec[95:64]; e.last = 0;
                  exq.push_back(e);
                  npush++; any_legal = 1;
               end else begin
                  m_drop++;
                  if (op != 8'd0) m_err = 1;
               end
            end
            if (s_axis_tlast) begin
               if (any_legal) exq[exq.size()-1].last = 1;
               else           exp_bd = 1;
            end
            void'(bq_data.pop_front());
            void'(bq_last.pop_front());
         end
         keep_valid = s_axis_tvalid && !acc;
         if (bq_data.size() == 0 && exq.size() == 0 && !exp_bd && !hs) idle++;
         else idle = 0;
         if (idle >= 2) break;
      end
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
      m_cmd_ready   = 1'b0;
      n_vec++;
      if (idle < 2) begin
         n_err++; $display("FAIL stream_timeout: got %0d cycles, want drain before %0d", c, max_cycles);
      end
      @(negedge aclk);
      n_vec++;
      if ({cmd_count, drop_count, err_sticky} !== {m_cmd, m_drop, m_err}) begin
         n_err++;
         $display("FAIL counters: got cmd=%0d drop=%0d err=%b want cmd=%0d drop=%0d err=%b",
                  cmd_count, drop_count, err_sticky, m_cmd, m_drop, m_err);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge aclk);
         n_vec++;
         if ({s_axis_tready, m_cmd_valid, batch_done} !== 3'b000) begin
            n_err++; $display("FAIL reset_hold: got rdy/vld/bd=%b%b%b want 000", s_axis_tready, m_cmd_valid, batch_done);
         end
      end
      areset = 1'b0;
      @(negedge aclk);
      n_vec++;
      if ({s_axis_tready, m_cmd_valid, m_cmd_last, batch_done} !== 4'b1000) begin
         n_err++; $display("FAIL reset_release: got rdy/vld/last/bd=%b%b%b%b want 1000",
                           s_axis_tready, m_cmd_valid, m_cmd_last, batch_done);
      end
      n_vec++;
      if ({cmd_count, drop_count, err_sticky} !== 65'd0) begin
         n_err++; $display("FAIL reset_counters: got cmd=%0d drop=%0d err=%b want 0 0 0", cmd_count, drop_count, err_sticky);
      end
      m_cmd = 0; m_drop = 0; m_err = 0;
   endtask

   task automatic test_legal_batch();
      ready_mode = 0;
      bq_data.push_back(mk_beat(8'd1, 8'd2, 8'd3, 8'd4)); bq_last.push_back(1);
      run_stream(100);
      n_vec++;
      if (hs_cyc.size() != 4 || acc_cyc.size() != 1) begin
         n_err++; $display("FAIL legal_batch_count: got %0d cmds want 4", hs_cyc.size());
      end else begin
         n_vec++;
         if (hs_cyc[0] != acc_cyc[0] + 1 || hs_cyc[3] != hs_cyc[0] + 3) begin
            n_err++; $display("FAIL legal_batch_timing: got first=%0d last=%0d want %0d %0d",
                              hs_cyc[0], hs_cyc[3], acc_cyc[0] + 1, acc_cyc[0] + 4);
         end
         n_vec++;
         if (bd_cyc.size() != 1 || bd_cyc[0] != hs_cyc[3] + 1) begin
            n_err++; $display("FAIL legal_batch_done: got %0d pulses want 1 at %0d", bd_cyc.size(), hs_cyc[3] + 1);
         end
      end
   endtask

   task automatic test_mixed();
      ready_mode = 0;
      bq_data.push_back(mk_beat(8'd0, 8'd7, 8'd2, 8'd0)); bq_last.push_back(0);
      run_stream(100);
      n_vec++;
      if (hs_cyc.size() != 1 || bd_cyc.size() != 0 || err_sticky !== 1'b1) begin
         n_err++; $display("FAIL mixed: got cmds=%0d bd=%0d err=%b want 1 0 1", hs_cyc.size(), bd_cyc.size(), err_sticky);
      end
   endtask

   task automatic test_all_nop();
      ready_mode = 0;
      bq_data.push_back(mk_beat(8'd0, 8'd0, 8'd0, 8'd0)); bq_last.push_back(1);
      run_stream(100);
      n_vec++;
      if (hs_cyc.size() != 0 || bd_cyc.size() != 1 || acc_cyc.size() != 1) begin
         n_err++; $display("FAIL all_nop: got cmds=%0d bd=%0d want 0 1", hs_cyc.size(), bd_cyc.size());
      end else begin
         n_vec++;
         if (bd_cyc[0] != acc_cyc[0] + 1) begin
            n_err++; $display("FAIL all_nop_bd_time: got %0d want %0d", bd_cyc[0], acc_cyc[0] + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      ready_mode = 0;
      for (int b = 0; b < 3; b++) begin
         bq_data.push_back(mk_beat(8'($urandom_range(1, 4)), 8'($urandom_range(1, 4)),
                                   8'($urandom_range(1, 4)), 8'($urandom_range(1, 4))));
         bq_last.push_back(b == 2);
      end
      run_stream(200);
      n_vec++;
      if (hs_cyc.size() != 12) begin
         n_err++; $display("FAIL b2b_count: got %0d want 12", hs_cyc.size());
      end else begin
         n_vec++;
         if (hs_cyc[11] - hs_cyc[0] != 11) begin
            n_err++; $display("FAIL b2b_bubbles: got span %0d want 11", hs_cyc[11] - hs_cyc[0]);
         end
      end
   endtask

   task automatic test_stall();
      ready_mode = 2;
      bq_data.push_back(mk_beat(8'd4, 8'd3, 8'd2, 8'd1)); bq_last.push_back(1);
      bq_data.push_back(mk_beat(8'd2, 8'd0, 8'd1, 8'd9)); bq_last.push_back(0);
      run_stream(200);
      n_vec++;
      if (hs_cyc.size() != 6) begin
         n_err++; $display("FAIL stall_count: got %0d want 6", hs_cyc.size());
      end
   endtask

   task automatic test_random();
      ready_mode = 1;
      for (int b = 0; b < 40; b++) begin
         bq_data.push_back(mk_beat(rand_op(), rand_op(), rand_op(), rand_op()));
         bq_last.push_back($urandom_range(0, 2) == 0);
      end
      run_stream(3000);
   endtask

   task automatic test_clear();
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b1; s_axis_tdata = mk_beat(8'd1, 8'd0, 8'd0, 8'd0); s_axis_tlast = 1'b0;
      m_cmd_ready = 1'b0;
      @(negedge aclk);
      n_vec++;
      if (s_axis_tready !== 1'b1) begin
         n_err++; $display("FAIL clear_accept: got tready %b want 1", s_axis_tready);
      end
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0; m_cmd_ready = 1'b1; ctrl_clear = 1'b1;
      @(negedge aclk);
      n_vec++;
      if (m_cmd_valid !== 1'b1) begin
         n_err++; $display("FAIL clear_valid: got %b want 1", m_cmd_valid);
      end
      @(posedge aclk); #1;
      ctrl_clear = 1'b0; m_cmd_ready = 1'b0;
      @(negedge aclk);
      n_vec++;
      if ({cmd_count, drop_count, err_sticky, m_cmd_valid} !== 66'd0) begin
         n_err++; $display("FAIL clear_result: got cmd=%0d drop=%0d err=%b vld=%b want 0 0 0 0",
                           cmd_count, drop_count, err_sticky, m_cmd_valid);
      end
      m_cmd = 0; m_drop = 0; m_err = 0;
   endtask

   task automatic test_reset_mid();
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b1; s_axis_tdata = mk_beat(8'd1, 8'd2, 8'd3, 8'd4); s_axis_tlast = 1'b1;
      m_cmd_ready = 1'b1;
      @(posedge aclk); #1;
      s_axis_tvalid = 1'b0;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      m_cmd_ready = 1'b0;
      @(negedge aclk);
      n_vec++;
      if ({m_cmd_valid, m_cmd_opcode} !== {1'b1, 8'd3}) begin
         n_err++; $display("FAIL mid_pending: got vld=%b op=%h want 1 03", m_cmd_valid, m_cmd_opcode);
      end
      #1 areset = 1'b1;
      #1;
      n_vec++;
      if ({m_cmd_valid, s_axis_tready} !== 2'b00) begin
         n_err++; $display("FAIL mid_reset_async: got vld=%b rdy=%b want 0 0", m_cmd_valid, s_axis_tready);
      end
      @(negedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      m_cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         n_vec++;
         if ({batch_done, m_cmd_valid} !== 2'b00 || cmd_count !== 32'd0) begin
            n_err++; $display("FAIL mid_reset_after: got bd=%b vld=%b cmd=%0d want 0 0 0", batch_done, m_cmd_valid, cmd_count);
         end
      end
      m_cmd_ready = 1'b0;
      m_cmd = 0; m_drop = 0; m_err = 0;
   endtask

   initial begin
      test_reset();
      test_legal_batch();
      test_mixed();
      test_all_nop();
      test_back_to_back();
      test_stall();
      test_random();
      test_clear();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axonerve_kvs_cmd_unpacker.md
Name: axonerve_kvs_cmd_unpacker

Overview:
- Stage directly downstream of the AXI4 read master's AXI4-Stream output in the KVS kernel. Takes the place the example adder held.
- Splits each wide beat into fixed-size KVS command records and filters out NOP and illegal records.
- Issues legal commands one per cycle to the Axonerve KVS engine command port.
- Reports end-of-batch (tlast) and maintains command and drop statistics for the control block.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, input stream width; must be a multiple of C_RECORD_WIDTH.
- C_RECORD_WIDTH, 128, bits per command record; LANES = C_AXIS_TDATA_WIDTH/C_RECORD_WIDTH (4).
- C_KEY_WIDTH, 64, key field width, record bits [C_KEY_WIDTH-1:0].
- C_VALUE_WIDTH, 32, value field width, bits directly above key.
- C_COUNT_WIDTH, 32, statistics counter width.

Ports:
- aclk  in  1  kernel clock; all logic single-clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  LANES records; lane 0 = bits [C_RECORD_WIDTH-1:0], processed first.
- s_axis_tlast  in  1  last beat of batch.
- m_cmd_valid  out  1  command valid.
- m_cmd_ready  in  1  KVS engine accepts command.
- m_cmd_opcode  out  8  record bits [127:120].
- m_cmd_key  out  C_KEY_WIDTH  record key.
- m_cmd_value  out  C_VALUE_WIDTH  record value.
- m_cmd_last  out  1  final emitted command of a tlast beat.
- batch_done  out  1  one-cycle pulse at end of batch.
- ctrl_clear  in  1  synchronous clear of counters and err_sticky.
- cmd_count  out  C_COUNT_WIDTH  commands handed off.
- drop_count  out  C_COUNT_WIDTH  records dropped (NOP + illegal).
- err_sticky  out  1  an illegal opcode was seen.

Behaviour:
- Opcode classification:
  - Legal: 1 SEARCH, 2 INSERT, 3 DELETE, 4 UPDATE.
  - NOP: 0, dropped silently.
  - Illegal: 5..255, dropped and sets err_sticky.
  - Reserved bits [119:C_KEY_WIDTH+C_VALUE_WIDTH] are ignored.
- Reset (areset high, async): beat buffer empty, pending mask 0, tlast flag 0, s_axis_tready=0 while areset is asserted, m_cmd_valid=0, m_cmd_last=0, batch_done=0, counters 0, err_sticky 0. The m_cmd data outputs are don't-care when m_cmd_valid=0.
- Reset mid-operation: buffered beat and pending records are discarded, with no batch_done.
- Storage: one beat buffer (data, LANES-bit pending mask, tlast flag).
  - States: EMPTY (mask=0) and HOLD (mask≠0).
- Accept (s_axis_tvalid && s_axis_tready): pending mask = per-lane legal bits.
  - Mask nonzero: go to HOLD.
  - Mask zero: beat is consumed without storing and stays in EMPTY. If tlast, batch_done pulses the next cycle.
- s_axis_tready is asserted when either condition holds:
  - mask==0, or
  - exactly one pending bit remains and an m_cmd handshake occurs this cycle.
  - This gives back-to-back beats with zero bubbles. s_axis_tready may depend combinationally on m_cmd_ready.
- Output is driven from registers through a lowest-set-bit priority select of the mask.
  - m_cmd_valid = (mask≠0).
  - No latency beyond the register: a command is valid the cycle after beat accept.
- On m_cmd handshake, clear the selected mask bit.
  - Throughput: 1 command/cycle.
  - Output is held stable while valid && !ready (AXI-Stream rule).
- m_cmd_last = buffered tlast && exactly one pending bit.
- batch_done (registered) pulses the cycle after the handshake with m_cmd_last=1.
- Counters:
  - cmd_count += 1 per m_cmd handshake.
  - drop_count += popcount(~legal mask) at accept (0..LANES).
  - Both wrap modulo 2^C_COUNT_WIDTH.
  - err_sticky is set at accept if any lane is illegal.
- ctrl_clear has priority over a same-cycle increment or set: result is 0, the event is lost.

Decomposition:
- Package axonerve_kvs_pkg:
  - opcode enum (NOP, SEARCH, INSERT, DELETE, UPDATE).
  - record field offset constants.
  - function is_legal_opcode.
- One natural sub-module: axonerve_kvs_lane_select. Combinational lowest-set-bit priority encoder returning index, one-hot, and "single bit remaining" flag.

Test Plan:
- Reset only (no input beats) -> s_axis_tready=0 while areset=1 and =1 after release; m_cmd_valid=0; counters 0.
- One beat with opcodes {1,2,3,4}, tlast=1, m_cmd_ready=1 ->
  - 4 consecutive commands starting the cycle after accept, lane 0 first.
  - m_cmd_last only on the 4th.
  - batch_done pulses 1 cycle after the 4th; cmd_count=4.
- Beat with opcodes {0,7,2,0}, tlast=0 -> one command (INSERT, lane 2 key/value); drop_count=3; err_sticky=1.
- Beat with all opcodes 0, tlast=1 -> no m_cmd_valid; batch_done pulses the cycle after accept; drop_count=4.
- Back-to-back 3 full-legal beats with m_cmd_ready=1 ->
  - 12 commands in 12 consecutive cycles, no bubbles.
  - Then m_cmd_ready toggled 1/0 -> outputs stable while stalled.
- ctrl_clear asserted in the same cycle as a handshake -> cmd_count=0 next cycle; areset asserted with 2 pending -> m_cmd_valid=0 immediately, no batch_done.
